// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg
//   Shared definitions for the intersection light controller and its monitor.
//   Contents: lane codes, rotation phase codes, the pair service order,
//   default dwell limits and the monitor FSM state type.
package traffic_light_pkg;

    // Lane codes
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Rotation phases: pairs are served in the order 1,3,2,4
    localparam logic [2:0] PH_G1 = 3'd0;
    localparam logic [2:0] PH_Y1 = 3'd1;
    localparam logic [2:0] PH_G3 = 3'd2;
    localparam logic [2:0] PH_Y3 = 3'd3;
    localparam logic [2:0] PH_G2 = 3'd4;
    localparam logic [2:0] PH_Y2 = 3'd5;
    localparam logic [2:0] PH_G4 = 3'd6;
    localparam logic [2:0] PH_Y4 = 3'd7;

    // Controller count limits; a phase dwells limit+1 cycles
    localparam logic [3:0] DEF_GREEN_TIME  = 4'd7;
    localparam logic [3:0] DEF_YELLOW_TIME = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } mon_state_t;

    // Rotation slot of pair index p (0..3 = pairs 1..4); order 1,3,2,4
    function automatic logic [1:0] slot_of_pair(input logic [1:0] p);
        case (p)
            2'd0:    return 2'd0;
            2'd1:    return 2'd2;
            2'd2:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// traffic_light_decode
//   Combinational decode of the eight lane codes into a single phase.
//   Ports:
//     rd1..rd4c     in   3  lane codes, pair k = rdk / rdkc
//     legal         out  1  exactly one pair non-red, matched, other lanes red
//     all_red       out  1  every lane RED
//     enc_err       out  1  some lane code outside {RED, YELLOW, GREEN}
//     conflict_err  out  1  more than one pair non-red, or rdk != rdkc
//     phase         out  3  decoded phase (meaningful only when legal)
module traffic_light_decode
    import traffic_light_pkg::*;
(
    input  logic [2:0] rd1,
    input  logic [2:0] rd1c,
    input  logic [2:0] rd2,
    input  logic [2:0] rd2c,
    input  logic [2:0] rd3,
    input  logic [2:0] rd3c,
    input  logic [2:0] rd4,
    input  logic [2:0] rd4c,
    output logic       legal,
    output logic       all_red,
    output logic       enc_err,
    output logic       conflict_err,
    output logic [2:0] phase
);

    logic [3:0][2:0] lane_a;
    logic [3:0][2:0] lane_b;
    logic [2:0]      active_cnt;
    logic            mismatch;

    assign lane_a = {rd4,  rd3,  rd2,  rd1};
    assign lane_b = {rd4c, rd3c, rd2c, rd1c};

    function automatic logic code_ok(input logic [2:0] c);
        return (c == RED) || (c == YELLOW) || (c == GREEN);
    endfunction

    always_comb begin
        enc_err    = 1'b0;
        mismatch   = 1'b0;
        active_cnt = 3'd0;
        phase      = 3'd0;
        for (int p = 0; p < 4; p++) begin
            if (!code_ok(lane_a[p]) || !code_ok(lane_b[p])) enc_err = 1'b1;
            if (lane_a[p] != lane_b[p]) mismatch = 1'b1;
            if ((lane_a[p] != RED) || (lane_b[p] != RED)) begin
                active_cnt = active_cnt + 3'd1;
                phase      = {slot_of_pair(2'(p)), lane_a[p] == YELLOW};
            end
        end
        conflict_err = mismatch || (active_cnt > 3'd1);
        all_red      = (active_cnt == 3'd0);
        legal        = !enc_err && !conflict_err && (active_cnt == 3'd1);
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive checker on the intersection light bus. Decodes the phase every
//   cycle, follows the rotation and raises sticky error flags. All outputs are
//   registered (one cycle after the sampled lanes).
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     rd1..rd4c     lane codes (3 bits each)
//     clr_err       synchronous clear of the sticky flags (a new error wins)
//     phase_valid   phase holds a decoded legal phase
//     phase         current phase 0..7 (G1 Y1 G3 Y3 G2 Y2 G4 Y4)
//     dwell         cycles in current phase, saturating at 15
//     err_encoding  sticky illegal lane code
//     err_conflict  sticky conflicting pairs / mismatched pair lanes
//     err_sequence  sticky out-of-order phase or all-red while tracking
//     err_timing    sticky dwell violation
//     err_any       OR of the four flags
//     cycle_count   completed Y4->G1 rotations while tracking, wraps
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter logic [3:0] GREEN_TIME  = DEF_GREEN_TIME,
    parameter logic [3:0] YELLOW_TIME = DEF_YELLOW_TIME
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rd1,
    input  logic [2:0]  rd1c,
    input  logic [2:0]  rd2,
    input  logic [2:0]  rd2c,
    input  logic [2:0]  rd3,
    input  logic [2:0]  rd3c,
    input  logic [2:0]  rd4,
    input  logic [2:0]  rd4c,
    input  logic        clr_err,
    output logic        phase_valid,
    output logic [2:0]  phase,
    output logic [3:0]  dwell,
    output logic        err_encoding,
    output logic        err_conflict,
    output logic        err_sequence,
    output logic        err_timing,
    output logic        err_any,
    output logic [15:0] cycle_count
);

    logic       legal_p0;
    logic       all_red_p0;
    logic       enc_err_p0;
    logic       conflict_err_p0;
    logic [2:0] phase_p0;

    mon_state_t  state, state_n;
    logic [2:0]  phase_n;
    logic [3:0]  dwell_n;
    logic        valid_n;
    logic [15:0] cycle_n;
    logic        timed, timed_n;   // err_timing already raised in this phase
    logic        set_seq, set_tim;
    logic        enc_n, conf_n, seq_n, tim_n;
    logic [4:0]  expected;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    traffic_light_decode u_decode (
        .rd1          (rd1),
        .rd1c         (rd1c),
        .rd2          (rd2),
        .rd2c         (rd2c),
        .rd3          (rd3),
        .rd3c         (rd3c),
        .rd4          (rd4),
        .rd4c         (rd4c),
        .legal        (legal_p0),
        .all_red      (all_red_p0),
        .enc_err      (enc_err_p0),
        .conflict_err (conflict_err_p0),
        .phase        (phase_p0)
    );

    // Odd phases are yellow
    assign expected = phase[0] ? ({1'b0, YELLOW_TIME} + 5'd1)
                               : ({1'b0, GREEN_TIME}  + 5'd1);

    always_comb begin
        state_n = state;
        phase_n = phase;
        dwell_n = dwell;
        valid_n = phase_valid;
        cycle_n = cycle_count;
        timed_n = timed;
        set_seq = 1'b0;
        set_tim = 1'b0;

        if (enc_err_p0 || conflict_err_p0) begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            phase_n = 3'd0;
            dwell_n = 4'd0;
        end else if (all_red_p0) begin
            if (state != ST_IDLE) set_seq = 1'b1;
            state_n = ST_IDLE;
            valid_n = 1'b0;
            phase_n = 3'd0;
            dwell_n = 4'd0;
        end else if (legal_p0) begin
            if (state == ST_IDLE) begin
                state_n = ST_ACQUIRE;
                phase_n = phase_p0;
                dwell_n = 4'd1;
                valid_n = 1'b1;
                timed_n = 1'b0;
            end else if (phase_p0 == phase) begin
                dwell_n = sat_inc(dwell);
                // The first (partial) phase in ACQUIRE is never timed
                if ((state == ST_TRACK) && !timed &&
                    (({1'b0, dwell} + 5'd1) > expected)) begin
                    set_tim = 1'b1;
                    timed_n = 1'b1;
                end
            end else if (phase_p0 == phase + 3'd1) begin
                if (state == ST_TRACK) begin
                    if ({1'b0, dwell} != expected) set_tim = 1'b1;
                    if (phase == PH_Y4) cycle_n = cycle_count + 16'd1;
                end
                state_n = ST_TRACK;
                phase_n = phase_p0;
                dwell_n = 4'd1;
                timed_n = 1'b0;
            end else begin
                set_seq = 1'b1;
                state_n = ST_ACQUIRE;
                phase_n = phase_p0;
                dwell_n = 4'd1;
                timed_n = 1'b0;
            end
        end

        // Set wins over clear
        enc_n  = enc_err_p0      | (err_encoding & ~clr_err);
        conf_n = conflict_err_p0 | (err_conflict & ~clr_err);
        seq_n  = set_seq         | (err_sequence & ~clr_err);
        tim_n  = set_tim         | (err_timing   & ~clr_err);
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            phase        <= 3'd0;
            dwell        <= 4'd0;
            phase_valid  <= 1'b0;
            cycle_count  <= 16'd0;
            timed        <= 1'b0;
            err_encoding <= 1'b0;
            err_conflict <= 1'b0;
            err_sequence <= 1'b0;
            err_timing   <= 1'b0;
            err_any      <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            dwell        <= dwell_n;
            phase_valid  <= valid_n;
            cycle_count  <= cycle_n;
            timed        <= timed_n;
            err_encoding <= enc_n;
            err_conflict <= conf_n;
            err_sequence <= seq_n;
            err_timing   <= tim_n;
            err_any      <= enc_n | conf_n | seq_n | tim_n;
        end
    end

endmodule
